// File: rtl/pattern_queue.sv
// Circular pattern-word queue with a launch/done handshake toward a downstream serializer.
// Optional replay mode: define PATTERN_QUEUE_LOOP_EN to add i_loop (launched words recirculate to the tail).
module pattern_queue #(
  parameter int DATA_BIT = 16,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr,
  input  logic [DATA_BIT-1:0]        i_wdata,
  input  logic                       i_enable,
  input  logic                       i_flush,
  input  logic                       i_done_tick,
`ifdef PATTERN_QUEUE_LOOP_EN
  input  logic                       i_loop,
`endif
  output logic                       o_start,
  output logic [DATA_BIT-1:0]        o_data,
  output logic                       o_busy,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_BIT-1:0]   mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  start_q, busy_q;
  logic [DATA_BIT-1:0]   data_q;
  logic                  loop, full, empty, pop, wr_acc, recirc, push;

`ifdef PATTERN_QUEUE_LOOP_EN
  assign loop = i_loop;
`else
  assign loop = 1'b0;
`endif

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Launch only from IDLE, so a done tick always costs one idle cycle before the next launch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable && !empty && !i_flush) begin
          pop     = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_done_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Full is judged on the pre-edge count; a same-cycle pop never rescues a write to a full queue.
  assign wr_acc = i_wr && !full && !i_flush && !loop;
  assign recirc = pop && loop;
  assign push   = wr_acc || recirc;

  always_comb begin
    count_d = count_q;
    if (i_flush) count_d = '0;
    else         count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= recirc ? mem_q[rptr_q] : i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      start_q <= pop;
      busy_q  <= (state_d == WAIT_DONE);
      if (pop) data_q <= mem_q[rptr_q];
      if (i_flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        wptr_q <= wptr_q + AW'(push);
        rptr_q <= rptr_q + AW'(pop);
      end
    end
  end

  assign o_start = start_q;
  assign o_data  = data_q;
  assign o_busy  = busy_q;
  assign o_full  = full;
  assign o_empty = empty;
  assign o_count = count_q;

endmodule

// File: tb/tb_pattern_queue.sv
// Scoreboard bench for pattern_queue: expected launch words queued at write time, compared on o_start.
module tb_pattern_queue;

  localparam int DW = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_wr, i_enable, i_flush, i_done_tick;
  logic [DW-1:0] i_wdata;
`ifdef PATTERN_QUEUE_LOOP_EN
  logic          i_loop;
`endif
  logic          o_start, o_busy, o_full, o_empty;
  logic [DW-1:0] o_data;
  logic [2:0]    o_count;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] sb [$];

  pattern_queue #(.DATA_BIT(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .i_wr(i_wr), .i_wdata(i_wdata), .i_enable(i_enable),
    .i_flush(i_flush), .i_done_tick(i_done_tick),
`ifdef PATTERN_QUEUE_LOOP_EN
    .i_loop(i_loop),
`endif
    .o_start(o_start), .o_data(o_data), .o_busy(o_busy), .o_full(o_full),
    .o_empty(o_empty), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    i_wr = 1'b1; i_wdata = d; tick(); i_wr = 1'b0;
  endtask

  task automatic pulse_done();
    i_done_tick = 1'b1; tick(); i_done_tick = 1'b0;
  endtask

  // Waits for a launch, compares it against the scoreboard head, then checks the pulse is one cycle.
  task automatic wait_launch(input int maxc, output int n);
    logic found;
    logic [DW-1:0] e;
    n = 0; found = 1'b0;
    while (!found && n < maxc) begin
      @(negedge clk); n++;
      if (o_start) found = 1'b1;
    end
    if (!found) chk("launch_timeout", 0, 1);
    else begin
      if (sb.size() == 0) chk("unexpected_launch", o_data, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("o_data", o_data, e);
      end
      chk("busy_on_start", o_busy, 1);
      @(negedge clk);
      chk("start_one_cycle", o_start, 0);
    end
  endtask

  task automatic no_start(input int ncyc);
    int s = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (o_start) s++;
    end
    chk("no_start", s, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; i_wr = 0; i_wdata = '0; i_enable = 0; i_flush = 0; i_done_tick = 0;
`ifdef PATTERN_QUEUE_LOOP_EN
    i_loop = 0;
`endif
    #3;
    chk("rst_count", o_count, 0); chk("rst_empty", o_empty, 1); chk("rst_full", o_full, 0);
    chk("rst_start", o_start, 0); chk("rst_busy", o_busy, 0); chk("rst_data", o_data, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Single word latency
    i_enable = 1'b1;
    sb.push_back(16'hA5A5);
    wr(16'hA5A5);
    wait_launch(2, n);
    chk("latency", n, 2);
    chk("empty_after_pop", o_empty, 1);
    chk("busy_hold", o_busy, 1);
    pulse_done();
    chk("busy_cleared", o_busy, 0);

    // Fill to full, drop the fifth, drain in order
    i_enable = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wr(DW'(i));
      if (i == 4) begin
        chk("full_flag", o_full, 1); chk("full_count", o_count, 4);
      end
    end
    chk("drop_count", o_count, 4);
    for (int i = 1; i <= 4; i++) sb.push_back(DW'(i));
    i_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_launch(4, n);
      pulse_done();
    end
    no_start(4);
    chk("drain_empty", o_empty, 1);
    chk("drain_sb", sb.size(), 0);

    // Flush while in flight
    i_enable = 1'b0;
    wr(16'hB001); wr(16'hB002); wr(16'hB003);
    sb.push_back(16'hB001);
    i_enable = 1'b1;
    wait_launch(4, n);
    chk("pre_flush_count", o_count, 2);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    chk("flush_count", o_count, 0);
    chk("flush_busy", o_busy, 1);
    chk("flush_data", o_data, 16'hB001);
    tick(); tick();
    chk("flush_busy_hold", o_busy, 1);
    pulse_done();
    no_start(6);
    chk("flush_busy_end", o_busy, 0);

    // Simultaneous write and pop at count 1
    i_enable = 1'b0;
    wr(16'hC001);
    sb.push_back(16'hC001); sb.push_back(16'hC002);
    i_enable = 1'b1;
    wr(16'hC002);
    chk("wr_pop_count", o_count, 1);
    wait_launch(2, n);
    pulse_done();
    wait_launch(4, n);
    pulse_done();
    chk("wr_pop_empty", o_empty, 1);

    // Reset during WAIT_DONE
    i_enable = 1'b0;
    wr(16'hD001); wr(16'hD002);
    sb.push_back(16'hD001);
    i_enable = 1'b1;
    wait_launch(4, n);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_count", o_count, 0); chk("mrst_empty", o_empty, 1); chk("mrst_busy", o_busy, 0);
    chk("mrst_start", o_start, 0); chk("mrst_data", o_data, 0); chk("mrst_full", o_full, 0);
    @(negedge clk); rst_n = 1'b1;
    pulse_done();
    no_start(5);
    chk("mrst_count_after", o_count, 0);

`ifdef PATTERN_QUEUE_LOOP_EN
    // Replay mode
    i_enable = 1'b0;
    wr(16'h1111); wr(16'h2222);
    i_loop = 1'b1;
    wr(16'h3333);
    chk("loop_drop_wr", o_count, 2);
    sb.push_back(16'h1111); sb.push_back(16'h2222); sb.push_back(16'h1111);
    i_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_launch(4, n);
      chk("loop_count", o_count, 2);
      if (i == 2) i_enable = 1'b0;
      pulse_done();
    end
    i_loop = 1'b0;
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    chk("loop_flush", o_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_queue.md
PATTERN_QUEUE -- requirements
Module: pattern_queue

Interface
REQ-001 Parameter DATA_BIT, default 16, width of each queued pattern word.
REQ-002 Parameter DEPTH, default 4, number of queue entries; legal values are powers of two from 2 to 16.
REQ-003 Port clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port i_wr  input  1  write strobe; pushes i_wdata when accepted.
REQ-006 Port i_wdata  input  DATA_BIT  pattern word to enqueue.
REQ-007 Port i_enable  input  1  when high, the dispatcher may launch queued words.
REQ-008 Port i_flush  input  1  discards all queued (not yet launched) words.
REQ-009 Port i_done_tick  input  1  one-cycle completion pulse from the downstream serializer.
REQ-010 Port o_start  output  1  one-cycle launch pulse to the serializer start input.
REQ-011 Port o_data  output  DATA_BIT  word presented to the serializer data input.
REQ-012 Port o_busy  output  1  high while a launched word awaits i_done_tick.
REQ-013 Port o_full, o_empty  output  1 each  queue status flags.
REQ-014 Port o_count  output  clog2(DEPTH)+1  number of queued words.

Function
REQ-015 Storage SHALL be a circular buffer with wrapping read/write pointers; o_full = (count==DEPTH), o_empty = (count==0).
REQ-016 A write SHALL be accepted when i_wr=1 and o_full=0, judged on the pre-edge count; a write while full SHALL be dropped with no state change, even if a pop occurs in the same cycle.
REQ-017 FSM states SHALL be IDLE and WAIT_DONE.
REQ-018 IDLE -> WAIT_DONE when i_enable=1 and o_empty=0: pop the head into the o_data register, pulse o_start high for exactly one cycle, and set o_busy.
REQ-019 WAIT_DONE -> IDLE on i_done_tick=1, clearing o_busy; the next launch SHALL occur no earlier than the following cycle.
REQ-020 Latency: a word written at edge N into an empty, enabled, idle queue SHALL produce o_start=1 and valid o_data in the cycle after edge N+1.
REQ-021 o_data SHALL hold its value from o_start until the next launch.
REQ-022 i_done_tick in IDLE SHALL be ignored.
REQ-023 A simultaneous write and pop SHALL leave o_count unchanged.
REQ-024 i_flush SHALL zero the pointers and the count in one cycle, with priority over a same-cycle write or pop; it SHALL NOT affect an in-flight word, o_busy, or o_data.
REQ-025 Deasserting i_enable SHALL block only new launches; a WAIT_DONE in progress SHALL still complete.

Reset
REQ-026 Asynchronous reset SHALL force: state IDLE, pointers 0, o_count=0, o_empty=1, o_full=0, o_start=0, o_busy=0, o_data=0.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight words; a later i_done_tick SHALL be ignored.

Configuration
REQ-028 Macro PATTERN_QUEUE_LOOP_EN: when defined, an input i_loop (1 bit) SHALL exist; with i_loop=1, each launched word SHALL be rewritten to the tail in the same cycle it is popped, so o_count stays constant and the pattern replays until i_loop=0 or i_flush; while looping, external writes SHALL be dropped.
REQ-029 When PATTERN_QUEUE_LOOP_EN is undefined, i_loop SHALL be absent and every launched word SHALL be consumed.

Verification
REQ-030 Reset, i_enable=1, write 0xA5A5 at one edge -> o_start pulses once, 2 cycles later, with o_data=0xA5A5 and o_busy=1; o_empty=1 afterwards.
REQ-031 i_enable=0, write 0x0001..0x0005 on consecutive cycles -> o_full=1 and o_count=4 after the fourth write; 0x0005 is dropped; after enabling with a done pulse per launch, exactly 0x0001..0x0004 are emitted in order.
REQ-032 In WAIT_DONE with 2 words queued, assert i_flush -> o_count=0; o_busy is held until i_done_tick; no further o_start occurs.
REQ-033 count=1, assert i_wr and a pop in the same cycle -> o_count stays 1; the written word launches next.
REQ-034 Pulse rst_n low during WAIT_DONE -> all outputs take their reset values; a following i_done_tick produces no o_start.
REQ-035 With PATTERN_QUEUE_LOOP_EN defined, queue 0x1111 and 0x2222 with i_loop=1 -> launches alternate 0x1111, 0x2222, 0x1111 and o_count remains 2.
